// File: rtl/vga_ball_animator.sv
// Bouncing-ball animator: on each vga_vs falling edge it advances the ball position
// and writes x/y/radius into the display peripheral's registers over Avalon-MM.
module vga_ball_animator #(
    parameter int unsigned RADIUS = 16,
    parameter int unsigned X0     = 30,
    parameter int unsigned Y0     = 30,
    parameter int unsigned STEP_X = 2,
    parameter int unsigned STEP_Y = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        vga_vs,
    input  logic        waitrequest,
    output logic        chipselect,
    output logic        write,
    output logic [2:0]  address,
    output logic [7:0]  writedata,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE, UPDATE, WR_XL, WR_XH, WR_YL, WR_YH, WR_R
    } state_t;

    localparam logic [10:0] XMIN = 11'(RADIUS);
    localparam logic [10:0] XMAX = 11'(639 - RADIUS);
    localparam logic [10:0] YMIN = 11'(RADIUS);
    localparam logic [10:0] YMAX = 11'(479 - RADIUS);
    localparam logic [10:0] SX   = 11'(STEP_X);
    localparam logic [10:0] SY   = 11'(STEP_Y);
    localparam logic [7:0]  R8   = 8'(RADIUS);

    state_t      state, state_nxt;
    logic [9:0]  x, y, x_nxt, y_nxt;
    logic        dir_x, dir_y, dir_x_nxt, dir_y_nxt;
    logic        vs_d;
    logic        frame_start;
    logic        accept;

    assign frame_start = vs_d & ~vga_vs;
    assign accept      = write & ~waitrequest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (frame_start && enable) state_nxt = UPDATE;
            UPDATE:  state_nxt = WR_XL;
            WR_XL:   if (!waitrequest) state_nxt = WR_XH;
            WR_XH:   if (!waitrequest) state_nxt = WR_YL;
            WR_YL:   if (!waitrequest) state_nxt = WR_YH;
            WR_YH:   if (!waitrequest) state_nxt = WR_R;
            WR_R:    if (!waitrequest) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        unique case (state)
            WR_XL: begin chipselect = 1'b1; write = 1'b1; address = 3'd3; writedata = {3'b0, x[4:0]}; end
            WR_XH: begin chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = {3'b0, x[9:5]}; end
            WR_YL: begin chipselect = 1'b1; write = 1'b1; address = 3'd5; writedata = {3'b0, y[4:0]}; end
            WR_YH: begin chipselect = 1'b1; write = 1'b1; address = 3'd6; writedata = {3'b0, y[9:5]}; end
            WR_R:  begin chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = R8; end
            default: ;
        endcase
    end

    // Bounce arithmetic in 11 bits so x+STEP near the edge cannot wrap.
    always_comb begin
        x_nxt     = x;
        dir_x_nxt = dir_x;
        if (dir_x) begin
            if ({1'b0, x} + SX >= XMAX) begin x_nxt = XMAX[9:0]; dir_x_nxt = 1'b0; end
            else                              x_nxt = 10'({1'b0, x} + SX);
        end else begin
            if ({1'b0, x} <= XMIN + SX) begin x_nxt = XMIN[9:0]; dir_x_nxt = 1'b1; end
            else                              x_nxt = 10'({1'b0, x} - SX);
        end
    end

    always_comb begin
        y_nxt     = y;
        dir_y_nxt = dir_y;
        if (dir_y) begin
            if ({1'b0, y} + SY >= YMAX) begin y_nxt = YMAX[9:0]; dir_y_nxt = 1'b0; end
            else                              y_nxt = 10'({1'b0, y} + SY);
        end else begin
            if ({1'b0, y} <= YMIN + SY) begin y_nxt = YMIN[9:0]; dir_y_nxt = 1'b1; end
            else                              y_nxt = 10'({1'b0, y} - SY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= 10'(X0);
            y           <= 10'(Y0);
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            vs_d        <= 1'b1;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            vs_d <= vga_vs;
            busy <= (state_nxt != IDLE);
            if (state == UPDATE) begin
                x     <= x_nxt;
                y     <= y_nxt;
                dir_x <= dir_x_nxt;
                dir_y <= dir_y_nxt;
            end
            if (frame_start && state != IDLE) overrun <= 1'b1;
            if (state == WR_R && accept) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_ball_animator.sv
// Directed bench for vga_ball_animator: a default instance plus one started near the
// right wall to exercise the bounce.
module tb_vga_ball_animator;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int unsigned dut;
        logic [2:0]  addr;
        logic [7:0]  data;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic vga_vs = 1'b1;
    logic vs2 = 1'b1;
    logic waitrequest = 1'b0;

    logic        chipselect, write, busy, overrun;
    logic [2:0]  address;
    logic [7:0]  writedata;
    logic [15:0] frame_count;

    logic        chipselect2, write2, busy2, overrun2;
    logic [2:0]  address2;
    logic [7:0]  writedata2;
    logic [15:0] frame_count2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_cycles = 0;
    int busy_cycles = 0;
    wr_t log1[$];
    wr_t log2[$];
    vec_t tab[15];

    vga_ball_animator dut (
        .clk(clk), .reset(reset), .enable(enable), .vga_vs(vga_vs),
        .waitrequest(waitrequest), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .busy(busy),
        .overrun(overrun), .frame_count(frame_count)
    );

    vga_ball_animator #(.X0(621)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .vga_vs(vs2),
        .waitrequest(waitrequest), .chipselect(chipselect2), .write(write2),
        .address(address2), .writedata(writedata2), .busy(busy2),
        .overrun(overrun2), .frame_count(frame_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (write && !waitrequest)  log1.push_back('{cyc, address, writedata});
        if (write2 && !waitrequest) log2.push_back('{cyc, address2, writedata2});
        if (write) wr_cycles++;
        if (busy)  busy_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_vs(input int which);
        @(posedge clk); #1;
        if (which == 1) vga_vs = 1'b0; else vs2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (which == 1) vga_vs = 1'b1; else vs2 = 1'b1;
    endtask

    task automatic wait_idle(input int which, input string name);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((which == 1 ? busy : busy2) == 1'b0) done = 1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s: busy still 1 after 40 cycles, required 0", name);
        end
    endtask

    task automatic wait_addr(input logic [2:0] a, input string name);
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (write && address == a) done = 1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s: no write to address %0d within 20 cycles", name, a);
        end
    endtask

    task automatic check_writes(input string name, input int ex, input int ey);
        logic [9:0] xv, yv;
        logic [2:0] ea[5];
        logic [7:0] ed[5];
        xv = 10'(ex);
        yv = 10'(ey);
        ea = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        ed = '{{3'b0, xv[4:0]}, {3'b0, xv[9:5]}, {3'b0, yv[4:0]}, {3'b0, yv[9:5]}, 8'h10};
        chk({name, "_count"}, log1.size(), 5);
        if (log1.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("%s_addr%0d", name, i), log1[i].addr, ea[i]);
                chk($sformatf("%s_data%0d", name, i), log1[i].data, ed[i]);
            end
        end
    endtask

    initial begin
        // Defaults from reset, then the X0=621 instance bouncing off XMAX=623.
        tab[0]  = '{1, 3'd3, 8'h00};
        tab[1]  = '{1, 3'd4, 8'h01};
        tab[2]  = '{1, 3'd5, 8'h1F};
        tab[3]  = '{1, 3'd6, 8'h00};
        tab[4]  = '{1, 3'd0, 8'h10};
        tab[5]  = '{2, 3'd3, 8'h0F};
        tab[6]  = '{2, 3'd4, 8'h13};
        tab[7]  = '{2, 3'd5, 8'h1F};
        tab[8]  = '{2, 3'd6, 8'h00};
        tab[9]  = '{2, 3'd0, 8'h10};
        tab[10] = '{2, 3'd3, 8'h0D};
        tab[11] = '{2, 3'd4, 8'h13};
        tab[12] = '{2, 3'd5, 8'h00};
        tab[13] = '{2, 3'd6, 8'h01};
        tab[14] = '{2, 3'd0, 8'h10};

        #1;
        chk("rst_write", write, 0);
        chk("rst_cs", chipselect, 0);
        chk("rst_addr", address, 0);
        chk("rst_data", writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_fc", frame_count, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        pulse_vs(2); wait_idle(2, "bounce1_idle");
        pulse_vs(2); wait_idle(2, "bounce2_idle");
        chk("bounce_fc", frame_count2, 2);

        pulse_vs(1); wait_idle(1, "basic_idle");
        chk("basic_fc", frame_count, 1);
        chk("log1_size", log1.size(), 5);
        chk("log2_size", log2.size(), 10);
        if (log1.size() == 5 && log2.size() == 10) begin
            for (int i = 0; i < 15; i++) begin
                wr_t w;
                w = (tab[i].dut == 1) ? log1[i] : log2[i - 5];
                chk($sformatf("vec%0d_addr", i), w.addr, tab[i].addr);
                chk($sformatf("vec%0d_data", i), w.data, tab[i].data);
            end
            chk("basic_consecutive", log1[4].cyc - log1[0].cyc, 4);
        end

        // Stall WR_XH for three edges; x=34, y=32 on this frame.
        log1.delete();
        pulse_vs(1);
        wait_addr(3'd4, "stall_reach");
        waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk($sformatf("stall_addr%0d", k), address, 4);
            chk($sformatf("stall_data%0d", k), writedata, 8'h01);
        end
        waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("stall_next_addr", address, 5);
        wait_idle(1, "stall_idle");
        check_writes("stall", 34, 32);
        chk("stall_fc", frame_count, 2);

        // Second falling edge during WR_YL is dropped; x=36, y=33.
        log1.delete();
        chk("pre_overrun", overrun, 0);
        pulse_vs(1);
        wait_addr(3'd5, "ovr_reach");
        vga_vs = 1'b0;
        @(posedge clk); #1;
        vga_vs = 1'b1;
        wait_idle(1, "ovr_idle");
        busy_cycles = 0;
        repeat (6) @(negedge clk);
        chk("ovr_no_extra", busy_cycles, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_fc", frame_count, 3);
        check_writes("ovr", 36, 33);

        // Reset while WR_YH is writing.
        pulse_vs(1);
        wait_addr(3'd6, "rst_reach");
        #1 reset = 1'b1;
        #1;
        chk("midrst_write", write, 0);
        chk("midrst_addr", address, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fc", frame_count, 0);
        chk("midrst_overrun", overrun, 0);
        #1 reset = 1'b0;
        wr_cycles = 0;
        busy_cycles = 0;
        repeat (5) @(negedge clk);
        chk("postrst_busy", busy_cycles, 0);
        chk("postrst_write", wr_cycles, 0);

        // Disabled frames do nothing; the following enabled frame starts from X0/Y0.
        enable = 1'b0;
        log1.delete();
        wr_cycles = 0;
        busy_cycles = 0;
        repeat (3) pulse_vs(1);
        repeat (4) @(negedge clk);
        chk("dis_write", wr_cycles, 0);
        chk("dis_busy", busy_cycles, 0);
        chk("dis_fc", frame_count, 0);
        enable = 1'b1;
        pulse_vs(1); wait_idle(1, "reen_idle");
        check_writes("reen", 32, 31);
        chk("reen_fc", frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vga_ball_animator.md
VGA_BALL_ANIMATOR -- requirements
Module: vga_ball_animator

Interface
REQ-001 Parameter RADIUS, default 16, ball radius written to register 0 and used as the bounce margin; legal range 1..200.
REQ-002 Parameter X0, default 30, reset x position.
REQ-003 Parameter Y0, default 30, reset y position.
REQ-004 Parameter STEP_X, default 2, unsigned x pixels moved per frame; legal range 1..15.
REQ-005 Parameter STEP_Y, default 1, unsigned y pixels moved per frame; legal range 1..15.
REQ-006 Port clk, input, 1, single clock for all logic.
REQ-007 Port reset, input, 1, asynchronous, active-high.
REQ-008 Port enable, input, 1, when high, each frame start triggers a position update and register writes.
REQ-009 Port vga_vs, input, 1, active-low vertical sync from the display peripheral, synchronous to clk.
REQ-010 Port waitrequest, input, 1, Avalon slave stall.
REQ-011 Port chipselect, output, 1, Avalon chip select.
REQ-012 Port write, output, 1, Avalon write strobe.
REQ-013 Port address, output, 3, Avalon register address.
REQ-014 Port writedata, output, 8, Avalon write data.
REQ-015 Port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-016 Port overrun, output, 1, sticky flag, set when a frame start arrives while busy.
REQ-017 Port frame_count, output, 16, number of completed update sequences; wraps from 65535 to 0.

Function
REQ-018 Frame start is a clk cycle where vga_vs is 0 and vga_vs registered one cycle earlier is 1 (falling edge).
REQ-019 FSM states: IDLE, UPDATE, WR_XL, WR_XH, WR_YL, WR_YH, WR_R.
- IDLE->UPDATE on frame start with enable=1.
- Frame start with enable=0 leaves the FSM in IDLE.
REQ-020 UPDATE lasts exactly one cycle, computes the new x, y and direction bits, then goes to WR_XL.
REQ-021 X update; XMIN=RADIUS, XMAX=639-RADIUS.
- dir_x=+: if x+STEP_X >= XMAX, x<=XMAX and dir_x<=-; else x<=x+STEP_X.
- dir_x=-: if x <= XMIN+STEP_X, x<=XMIN and dir_x<=+; else x<=x-STEP_X.
REQ-022 Y update follows the same rule with YMIN=RADIUS, YMAX=479-RADIUS and STEP_Y.
REQ-023 x and y are 10-bit unsigned; all comparisons use at least 11 bits so no wrap occurs.
REQ-024 Write sequence, one write per state:
- WR_XL: address 3, data {3'b0, x[4:0]}.
- WR_XH: address 4, data {3'b0, x[9:5]}.
- WR_YL: address 5, data {3'b0, y[4:0]}.
- WR_YH: address 6, data {3'b0, y[9:5]}.
- WR_R: address 0, data RADIUS[7:0].
REQ-025 In each WR_* state, chipselect=1 and write=1, with address and writedata stable until acceptance.
REQ-026 A write is accepted at a rising edge where write=1 and waitrequest=0; the FSM then advances to the next state.
REQ-027 On acceptance in WR_R, frame_count increments and the FSM returns to IDLE.
REQ-028 With waitrequest held 0, a sequence takes 6 cycles from UPDATE to the return to IDLE; write is high for 5 consecutive cycles.
REQ-029 Outside WR_* states, chipselect=0, write=0, address=0 and writedata=0.
REQ-030 A frame start while busy=1 is dropped and sets overrun=1; only reset clears overrun.
REQ-031 Deasserting enable mid-sequence does not abort the sequence.
REQ-032 busy is a registered output and equals (state != IDLE).

Reset
REQ-033 Reset forces the following immediately, regardless of clk:
- state=IDLE; x=X0; y=Y0; dir_x=+; dir_y=+.
- vga_vs history register=1; overrun=0; frame_count=0.
- chipselect=0; write=0; address=0; writedata=0; busy=0.
REQ-034 Reset asserted mid-write aborts the transfer; after release, the FSM waits for the next frame start.

Verification
REQ-035 Defaults, enable=1, waitrequest=0, one vga_vs falling edge -> writes (3,0x00),(4,0x01),(5,0x1F),(6,0x00),(0,0x10) on 5 consecutive cycles, then frame_count=1.
REQ-036 x=621, dir_x=+, STEP_X=2, RADIUS=16 (XMAX=623), one frame -> x=623, dir_x=-; next frame -> x=621.
REQ-037 waitrequest held 1 for 3 cycles during WR_XH -> address=4 and writedata held for 4 cycles, then the sequence completes normally.
REQ-038 Second vga_vs falling edge during WR_YL -> overrun=1, no extra sequence, frame_count increments by 1 only.
REQ-039 Reset pulse while write=1 in WR_YH -> write=0 immediately, x=30, y=30, frame_count=0.
REQ-040 enable=0 across 3 vga_vs falling edges -> no write asserted, busy stays 0, x=30.
